// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the CPU/debug memory port arbiter.
package mem_port_arbiter_pkg;

  // FSM state encodings (3-bit).
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GNT_CPU = 3'd1,
    ST_GNT_DBG = 3'd2,
    ST_RD_CPU  = 3'd3,
    ST_RD_DBG  = 3'd4
  } arb_state_e;

  // Port identifiers used by the datapath mux.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Bits needed to hold a counter value of 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating up-counter tracking how many times DBG has lost to CPU in a row.
module starve_counter #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,   // synchronous, active low
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic [W-1:0] sat_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops at the saturation value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                         cnt_d = '0;
    else if (inc_i && (cnt_q < sat_i)) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous RAM between the CPU datapath and a
// debug/program-loader port. CPU has fixed priority, DBG is forced in after
// MAX_WAIT consecutive CPU wins, and dbg_lock hands the bus to DBG exclusively.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  input  logic          dbg_lock,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int           CW      = cnt_width(MAX_WAIT);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  arb_state_e    state_q, state_d;
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] rdata_q;

  logic          win_cpu, win_dbg, win_any;
  logic          sel_port;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [CW-1:0] starve_cnt;
  logic          starve_inc, starve_clr;
  logic          in_idle, in_rd;

  assign in_idle = (state_q == ST_IDLE);
  assign in_rd   = (state_q == ST_RD_CPU) || (state_q == ST_RD_DBG);

  // Arbitration is only evaluated in IDLE; lock first, then CPU unless DBG is starved.
  always_comb begin
    win_cpu = 1'b0;
    win_dbg = 1'b0;
    if (in_idle) begin
      if (dbg_lock && dbg_req)
        win_dbg = 1'b1;
      else if (cpu_req && !dbg_lock && (!dbg_req || (starve_cnt < MAX_CNT)))
        win_cpu = 1'b1;
      else if (dbg_req)
        win_dbg = 1'b1;
    end
  end

  assign win_any  = win_cpu || win_dbg;
  assign sel_port = win_dbg ? PORT_DBG : PORT_CPU;

  // Request fields of whichever port won this cycle.
  always_comb begin
    req_we    = cpu_we;
    req_addr  = cpu_addr;
    req_wdata = cpu_wdata;
    if (sel_port == PORT_DBG) begin
      req_we    = dbg_we;
      req_addr  = dbg_addr;
      req_wdata = dbg_wdata;
    end
  end

  // Next-state logic: grant lasts one cycle, reads take one extra cycle for data.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_cpu)      state_d = ST_GNT_CPU;
        else if (win_dbg) state_d = ST_GNT_DBG;
      end
      ST_GNT_CPU: state_d = mem_we_q ? ST_IDLE : ST_RD_CPU;
      ST_GNT_DBG: state_d = mem_we_q ? ST_IDLE : ST_RD_DBG;
      ST_RD_CPU:  state_d = ST_IDLE;
      ST_RD_DBG:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and RAM-side registers; mem_en/mem_we are only set for the grant cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q  <= state_d;
      mem_en_q <= win_any;
      mem_we_q <= win_any && req_we;
      if (win_any) begin
        mem_addr_q  <= req_addr;
        mem_wdata_q <= req_wdata;
      end
      if (in_rd) rdata_q <= mem_rdata;
    end
  end

  // A CPU win against a waiting DBG counts toward starvation; DBG service or
  // an idle cycle without a DBG request resets the count.
  assign starve_inc = win_cpu && dbg_req;
  assign starve_clr = win_dbg || (in_idle && !dbg_req);

  starve_counter #(.W(CW)) u_starve (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (starve_inc),
    .clr_i   (starve_clr),
    .sat_i   (MAX_CNT),
    .cnt_o   (starve_cnt)
  );

  assign cpu_gnt    = (state_q == ST_GNT_CPU);
  assign dbg_gnt    = (state_q == ST_GNT_DBG);
  assign cpu_rvalid = (state_q == ST_RD_CPU);
  assign dbg_rvalid = (state_q == ST_RD_DBG);
  assign cpu_stall  = cpu_req && !cpu_gnt;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // The RAM only presents data during the RD cycle, so forward it alongside
  // rvalid and hold the captured copy afterwards.
  assign rdata = in_rd ? mem_rdata : rdata_q;

endmodule
